// File: rtl/rv32_pkg.sv
// Shared RV32I definitions for the instruction encoder/writer.
// Contents:
//   OP_*            7-bit base opcodes accepted by the encoder
//   writer_state_t  instruction-memory writer states
package rv32_pkg;

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_REG    = 7'h33;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_JAL    = 7'h6F;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        WRITE = 2'd2,
        FULL  = 2'd3
    } writer_state_t;

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I field packer: the inverse of the core's field decoder.
// Ports:
//   op, func, op_2   opcode, funct3, funct7
//   rd, rs1, rs2     register indices
//   imm              20-bit immediate in the decoder's packed layout
//   word             encoded 32-bit instruction (0 when illegal)
//   legal            1 when op is one of the supported base opcodes
module instr_pack
    import rv32_pkg::*;
(
    input  logic [6:0]  op,
    input  logic [2:0]  func,
    input  logic [6:0]  op_2,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [19:0] imm,
    output logic [31:0] word,
    output logic        legal
);

    always_comb begin
        word  = 32'h0;
        legal = 1'b1;
        case (op)
            OP_REG:
                word = {op_2, rs2, rs1, func, rd, op};
            // Shift-immediates carry funct7 in imm[11:5], so no special case.
            OP_LOAD, OP_IMM, OP_JALR:
                word = {imm[11:0], rs1, func, rd, op};
            OP_STORE:
                word = {imm[11:5], rs2, rs1, func, imm[4:0], op};
            // Branch/jump immediates are already bit-scrambled by the decoder
            // layout; these concatenations just put each piece back in place.
            OP_BRANCH:
                word = {imm[11], imm[9:4], rs2, rs1, func, imm[3:0], imm[10], op};
            OP_JAL:
                word = {imm[19], imm[9:0], imm[10], imm[18:11], rd, op};
            OP_LUI, OP_AUIPC:
                word = {imm, rd, op};
            default: begin
                word  = 32'h0;
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instr_encode_writer.sv
// Encodes RV32I field bundles and writes them to instruction memory at
// consecutive word addresses, starting from base_addr after each start.
// Ports:
//   clk, rst            clock, async active-high reset
//   start, base_addr    arm the writer at a (word-aligned) base address
//   in_valid/in_ready   field bundle handshake
//   op..imm             instruction fields
//   mem_we/mem_ack      write request held until acknowledged
//   mem_addr/mem_wdata  write address and encoded word
//   count, full         words written since start; count reached DEPTH
//   err_illegal         one-cycle pulse after an unsupported opcode is consumed
//
// state | meaning
// IDLE  | waiting for first start after reset
// ARMED | accepting a field bundle
// WRITE | mem_we held, waiting for mem_ack
// FULL  | DEPTH words written, waiting for start
module instr_encode_writer
    import rv32_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        op,
    input  logic [2:0]        func,
    input  logic [6:0]        op_2,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [19:0]       imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] count,
    output logic              full,
    output logic              err_illegal
);

    writer_state_t     state;
    logic [ADDR_W-1:0] next_addr;
    logic [ADDR_W-1:0] base_aligned;
    logic [ADDR_W-1:0] count_inc;
    logic [31:0]       packed_word;
    logic              packed_legal;

    assign base_aligned = {base_addr[ADDR_W-1:2], 2'b00};
    assign count_inc    = count + ADDR_W'(1);

    // start wins over a bundle offered in the same ARMED cycle.
    assign in_ready = (state == ARMED) && !start;

    instr_pack u_pack (
        .op    (op),
        .func  (func),
        .op_2  (op_2),
        .rd    (rd),
        .rs1   (rs1),
        .rs2   (rs2),
        .imm   (imm),
        .word  (packed_word),
        .legal (packed_legal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            next_addr   <= '0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= 32'h0;
            count       <= '0;
            full        <= 1'b0;
            err_illegal <= 1'b0;
        end else begin
            err_illegal <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        next_addr <= base_aligned;
                        count     <= '0;
                        state     <= ARMED;
                    end
                end
                ARMED: begin
                    if (start) begin
                        next_addr <= base_aligned;
                        count     <= '0;
                    end else if (in_valid) begin
                        if (packed_legal) begin
                            mem_wdata <= packed_word;
                            mem_addr  <= next_addr;
                            mem_we    <= 1'b1;
                            state     <= WRITE;
                        end else begin
                            err_illegal <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (mem_ack) begin
                        mem_we    <= 1'b0;
                        next_addr <= mem_addr + ADDR_W'(4);
                        count     <= count_inc;
                        if (count_inc == ADDR_W'(DEPTH)) begin
                            full  <= 1'b1;
                            state <= FULL;
                        end else begin
                            state <= ARMED;
                        end
                    end
                end
                FULL: begin
                    if (start) begin
                        next_addr <= base_aligned;
                        count     <= '0;
                        full      <= 1'b0;
                        state     <= ARMED;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encode_writer.sv
// Scoreboard bench for instr_encode_writer: expected {addr, word} pairs are
// queued when a bundle is accepted and compared when memory acknowledges.
module tb_instr_encode_writer;

    localparam int ADDR_W   = 32;
    localparam int TB_DEPTH = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              in_valid;
    logic              in_ready;
    logic [6:0]        op;
    logic [2:0]        func;
    logic [6:0]        op_2;
    logic [4:0]        rd, rs1, rs2;
    logic [19:0]       imm;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [ADDR_W-1:0] count;
    logic              full;
    logic              err_illegal;

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0]       sb[$];
    logic [ADDR_W-1:0] model_addr = '0;
    int                ack_delay = 0;
    int                wait_cnt = 0;
    logic [ADDR_W-1:0] held_addr;
    logic [31:0]       held_data;

    always #5 clk = ~clk;

    instr_encode_writer #(.ADDR_W(ADDR_W), .DEPTH(TB_DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .base_addr   (base_addr),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op          (op),
        .func        (func),
        .op_2        (op_2),
        .rd          (rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .imm         (imm),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .count       (count),
        .full        (full),
        .err_illegal (err_illegal)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Independent reference encoder: returns {legal, word}.
    function automatic logic [32:0] ref_enc(input logic [6:0] o, input logic [2:0] f3,
                                            input logic [6:0] f7, input logic [4:0] d,
                                            input logic [4:0] s1, input logic [4:0] s2,
                                            input logic [19:0] im);
        logic [31:0] w;
        logic [31:0] base;
        logic        ok;
        ok   = 1'b1;
        base = (32'(s1) << 15) | (32'(f3) << 12) | 32'(o);
        case (o)
            7'h33: w = (32'(f7) << 25) | (32'(s2) << 20) | base | (32'(d) << 7);
            7'h03, 7'h13, 7'h67: w = (32'(im[11:0]) << 20) | base | (32'(d) << 7);
            7'h23: w = (32'(im[11:5]) << 25) | (32'(s2) << 20) | base | (32'(im[4:0]) << 7);
            7'h63: w = (32'(im[11]) << 31) | (32'(im[9:4]) << 25) | (32'(s2) << 20) | base
                       | (32'(im[3:0]) << 8) | (32'(im[10]) << 7);
            7'h6F: w = (32'(im[19]) << 31) | (32'(im[9:0]) << 21) | (32'(im[10]) << 20)
                       | (32'(im[18:11]) << 12) | (32'(d) << 7) | 32'(o);
            7'h37, 7'h17: w = (32'(im) << 12) | (32'(d) << 7) | 32'(o);
            default: begin w = 32'h0; ok = 1'b0; end
        endcase
        return {ok, w};
    endfunction

    // Memory responder: acks after ack_delay waiting cycles, checks the
    // request is stable while held and matches the scoreboard head.
    initial begin : responder
        mem_ack = 1'b0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (mem_we) begin
                if (wait_cnt == 0) begin
                    held_addr = mem_addr;
                    held_data = mem_wdata;
                end else begin
                    check_val("hold_addr", mem_addr, held_addr);
                    check_val("hold_data", mem_wdata, held_data);
                end
                check_val("write_in_ready", in_ready, 1'b0);
                if (wait_cnt >= ack_delay) begin
                    mem_ack = 1'b1;
                    wait_cnt = 0;
                    check_val("sb_nonempty", 64'(sb.size() > 0), 64'd1);
                    if (sb.size() > 0) begin
                        logic [63:0] e;
                        e = sb.pop_front();
                        check_val("wr_addr", mem_addr, e[63:32]);
                        check_val("wr_data", mem_wdata, e[31:0]);
                    end
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic do_start(input logic [ADDR_W-1:0] b);
        @(negedge clk);
        start = 1'b1;
        base_addr = b;
        @(negedge clk);
        start = 1'b0;
        model_addr = {b[ADDR_W-1:2], 2'b00};
    endtask

    task automatic send(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [19:0] im, input logic [31:0] exp_w, input logic exp_ok);
        int n;
        @(negedge clk);
        op = o; func = f3; op_2 = f7; rd = d; rs1 = s1; rs2 = s2; imm = im;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check_val("accept_timeout", in_ready, 1'b1);
            in_valid = 1'b0;
            return;
        end
        if (exp_ok) begin
            sb.push_back({model_addr, exp_w});
            model_addr = model_addr + 4;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_val("we_latency", mem_we, exp_ok);
        check_val("err_pulse", err_illegal, !exp_ok);
        if (!exp_ok) begin
            @(posedge clk);
            #1;
            check_val("err_one_cycle", err_illegal, 1'b0);
            check_val("illegal_no_we", mem_we, 1'b0);
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        @(negedge clk);
        while ((sb.size() != 0 || mem_we) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_val("drain", 64'(sb.size()) | 64'(mem_we), 64'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [6:0]  legal_ops [9];
        logic [32:0] r;
        logic [6:0]  o;
        int          n_ok;
        legal_ops = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h33};

        rst = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0;
        op = '0; func = '0; op_2 = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
        repeat (3) @(negedge clk);
        check_val("rst_in_ready", in_ready, 1'b0);
        check_val("rst_mem_we", mem_we, 1'b0);
        check_val("rst_full", full, 1'b0);
        check_val("rst_err", err_illegal, 1'b0);
        check_val("rst_addr", mem_addr, 0);
        check_val("rst_wdata", mem_wdata, 0);
        check_val("rst_count", count, 0);
        rst = 1'b0;
        @(negedge clk);
        check_val("idle_in_ready", in_ready, 1'b0);

        do_start(32'h100);
        #1 check_val("armed_in_ready", in_ready, 1'b1);

        ack_delay = 0;
        send(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 20'd5, 32'h00500093, 1'b1);
        wait_done();
        check_val("count_after_1", count, 1);
        send(7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 20'd8, 32'h0020A423, 1'b1);
        send(7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 20'h004, 32'h00208463, 1'b1);
        send(7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 20'h00001, 32'h002000EF, 1'b1);
        send(7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 20'h12345, 32'h123452B7, 1'b1);
        wait_done();
        send(7'h7F, 3'd0, 7'd0, 5'd1, 5'd1, 5'd1, 20'h0, 32'h0, 1'b0);
        check_val("count_after_illegal", count, 5);
        send(7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 20'h0, 32'h002081B3, 1'b1);
        wait_done();

        // Delayed ack, with a start pulse during WRITE that must be ignored.
        ack_delay = 3;
        send(7'h03, 3'd2, 7'd0, 5'd4, 5'd1, 5'd0, 20'd12, 32'h00C0A203, 1'b1);
        @(negedge clk);
        start = 1'b1;
        base_addr = 32'h800;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        check_val("count_after_delay", count, 7);

        ack_delay = 0;
        send(7'h17, 3'd0, 7'd0, 5'd6, 5'd0, 5'd0, 20'hABCDE, 32'hABCDE317, 1'b1);
        wait_done();
        check_val("full_flag", full, 1'b1);
        check_val("full_in_ready", in_ready, 1'b0);
        check_val("full_count", count, TB_DEPTH);

        do_start(32'h200);
        #1;
        check_val("restart_count", count, 0);
        check_val("restart_full", full, 1'b0);
        check_val("restart_in_ready", in_ready, 1'b1);

        // start and a bundle in the same cycle: the bundle is not taken.
        @(negedge clk);
        start = 1'b1;
        base_addr = 32'h300;
        op = 7'h13; func = 3'd0; rd = 5'd1; rs1 = 5'd0; imm = 20'd1;
        in_valid = 1'b1;
        #1 check_val("start_blocks_ready", in_ready, 1'b0);
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b0;
        model_addr = 32'h300;
        #1 check_val("start_no_accept", mem_we, 1'b0);

        n_ok = 0;
        for (int i = 0; i < 6; i++) begin
            o = ($urandom_range(0, 3) == 0) ? 7'h0B : legal_ops[$urandom_range(0, 8)];
            func = 3'($urandom); op_2 = 7'($urandom);
            rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom); imm = 20'($urandom);
            r = ref_enc(o, func, op_2, rd, rs1, rs2, imm);
            ack_delay = $urandom_range(0, 2);
            send(o, func, op_2, rd, rs1, rs2, imm, r[31:0], r[32]);
            if (r[32]) n_ok++;
            wait_done();
        end
        check_val("rand_count", count, n_ok);

        // Address wrap and base alignment.
        ack_delay = 0;
        do_start(32'hFFFF_FFFE);
        send(7'h37, 3'd0, 7'd0, 5'd7, 5'd0, 5'd0, 20'hFEDCB, 32'hFEDCB3B7, 1'b1);
        send(7'h13, 3'd0, 7'd0, 5'd2, 5'd2, 5'd0, 20'hFFF, 32'hFFF10113, 1'b1);
        wait_done();
        check_val("wrap_count", count, 2);

        // Reset while a write is pending.
        ack_delay = 20;
        send(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 20'd9, 32'h00900093, 1'b1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_val("rst_mid_we", mem_we, 1'b0);
        check_val("rst_mid_ready", in_ready, 1'b0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_val("post_rst_count", count, 0);
        check_val("post_rst_addr", mem_addr, 0);
        check_val("post_rst_idle", in_ready, 1'b0);
        check_val("post_rst_we", mem_we, 1'b0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instr_encode_writer.md
Name: instr_encode_writer

Overview:
- Inverse of the core's instruction field decoder: accepts RV32I instruction fields (op, func, op_2, rd, rs1, rs2, imm) over a valid/ready handshake.
- Packs the fields into a 32-bit RV32I instruction word and writes it to instruction memory at consecutive word addresses.
- Used by the bootloader/self-test path to fill instruction memory before the core is released.
- The imm field uses the same 20-bit packed layout the decoder produces, so decoder output fed back in reproduces the original word.

Parameters:
- ADDR_W, 32, width of mem_addr (byte address).
- DEPTH, 1024, maximum number of words written per start; reaching it enters FULL.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  pulse; loads base_addr and clears count. Ignored while in WRITE.
- base_addr  input  ADDR_W  first byte address; low 2 bits are forced to 0.
- in_valid  input  1  field bundle valid.
- in_ready  output  1  block can accept a bundle.
- op  input  7  opcode, instr[6:0].
- func  input  3  funct3.
- op_2  input  7  funct7, R-type only.
- rd, rs1, rs2  input  5 each  register indices.
- imm  input  20  packed immediate, decoder layout.
- mem_we  output  1  write request, held until mem_ack.
- mem_addr  output  ADDR_W  write byte address.
- mem_wdata  output  32  encoded instruction.
- mem_ack  input  1  memory accepted the write this cycle.
- count  output  ADDR_W  words written since the last start.
- full  output  1  count == DEPTH.
- err_illegal  output  1  one-cycle pulse: unsupported opcode was consumed.

Behaviour:
- Reset (async, rst=1):
  - State = IDLE.
  - in_ready, mem_we, full, err_illegal = 0.
  - mem_addr, mem_wdata, count = 0.
  - Reset mid-WRITE drops mem_we immediately and discards the pending word.
- States:
  - IDLE: in_ready=0. start -> ARMED.
  - ARMED: in_ready=1. On in_valid&in_ready:
    - Legal opcode: register the packed word into mem_wdata and the current address into mem_addr; -> WRITE. mem_we is high in the following cycle (latency 1).
    - Illegal opcode: err_illegal=1 for the next cycle only; bundle consumed; stay ARMED; address and count unchanged.
  - WRITE: in_ready=0, mem_we=1. mem_addr and mem_wdata stay stable until mem_ack. On mem_ack:
    - Address += 4, wrapping modulo 2^ADDR_W.
    - count += 1.
    - Next state is FULL if the new count == DEPTH, else ARMED.
  - FULL: full=1, in_ready=0. start -> ARMED (count=0, full=0).
- start in ARMED: reloads base_addr and clears count; any bundle offered in that same cycle is not accepted (in_ready is forced to 0 that cycle).
- Packing: fields not used by a format are ignored; unused bits come from the listed fields only.
  - R-type, op 0x33: {op_2, rs2, rs1, func, rd, op}.
  - I-type, op 0x03, 0x13, 0x67: {imm[11:0], rs1, func, rd, op}. For shift-immediates, the caller places funct7 in imm[11:5].
  - S-type, op 0x23: {imm[11:5], rs2, rs1, func, imm[4:0], op}.
  - B-type, op 0x63: instr[31]=imm[11], instr[7]=imm[10], instr[30:25]=imm[9:4], instr[11:8]=imm[3:0]; plus rs2, rs1, func, op.
  - J-type, op 0x6F: instr[31]=imm[19], instr[19:12]=imm[18:11], instr[20]=imm[10], instr[30:21]=imm[9:0]; plus rd, op.
  - U-type, op 0x37, 0x17: {imm[19:0], rd, op}.
  - Any other opcode is illegal.

Decomposition:
- Shared package rv32_pkg:
  - Opcode constants: OP_LOAD, OP_IMM, OP_JALR, OP_STORE, OP_BRANCH, OP_JAL, OP_LUI, OP_AUIPC, OP_REG.
  - Writer state enum: IDLE, ARMED, WRITE, FULL.
- One combinational sub-module, instr_pack: fields -> {word[31:0], legal}. It is reusable by the testbench as the reference encoder.

Test Plan:
- start with base_addr=0x100, then op=0x13, rd=1, rs1=0, func=0, imm=5 -> next cycle mem_we=1, mem_addr=0x100, mem_wdata=0x00500093; after mem_ack, count=1.
- op=0x23, func=2, rs1=1, rs2=2, imm=8 -> mem_wdata=0x0020A423 at 0x104. Then op=0x63, func=0, rs1=1, rs2=2, imm=0x004 -> 0x00208463 at 0x108.
- op=0x6F, rd=1, imm=0x00001 -> 0x002000EF. Then op=0x37, rd=5, imm=0x12345 -> 0x123452B7.
- op=0x7F -> err_illegal high exactly 1 cycle, no mem_we, next legal word still written at the unchanged address.
- mem_ack delayed 3 cycles -> mem_we, mem_addr and mem_wdata stable throughout, in_ready=0.
- DEPTH=2: two acked writes -> full=1, in_ready=0. start -> count=0, ARMED.
- rst asserted mid-WRITE -> mem_we=0 asynchronously, state IDLE.
